oneshot_scheduler: RTL and testbench
====================================

Name: oneshot_scheduler

Overview:
- Time-shares one 555-style monostable counter between NUM_CH trigger sources, for example the paddle-hit, wall-bounce and score sound events.
- Each channel has its own pulse length. Falling edges on each channel's trigger are latched as pending requests.
- Pending requests are served one at a time in fixed priority, lowest index first.
- Outputs are per-channel one-hot pulses that feed the sound mixer.

Parameters:
NUM_CH, 3, number of trigger channels (2..8)
CNT_W, 20, counter width; every COUNTS entry must be in 1..2**CNT_W
COUNTS, {28636, 7159, 114545}, packed array [NUM_CH][CNT_W]; pulse length of channel i in CLK cycles
CH_W, $clog2(NUM_CH), width of ACTIVE_ID (derived, not overridden)

Ports:
CLK  in  1  counting clock; all state updates on its rising edge
RESET  in  1  asynchronous, active-high reset
TRG_N  in  NUM_CH  per-channel trigger; a falling edge requests a pulse
MUTE  in  1  high: discard new edges and clear all pending requests
OUT  out  NUM_CH  OUT[i] high while channel i's pulse is running
BUSY  out  1  high whenever state is not IDLE
ACTIVE_ID  out  CH_W  channel currently or last served

Behaviour:
- Reset (async assert, all registers):
  - state=IDLE, counter=0, pending=0, prev_trg_n=0, ACTIVE_ID=0.
  - OUT=0 and BUSY=0 immediately on assertion.
  - Because prev_trg_n resets to 0, a TRG_N held low through reset release produces no edge.
- Edge detect, per channel:
  - prev_trg_n[i] <= TRG_N[i] every cycle.
  - detect[i] = prev_trg_n[i] & ~TRG_N[i], combinational.
- Pending register, per channel:
  - Set on detect[i], unless MUTE=1 or channel i is active (state COUNT/GAP with ACTIVE_ID==i). The oneshot is non-retriggerable; such edges are dropped, not queued.
  - Detect while pending[i] is already set: no effect; multiple edges collapse to one request.
  - Cleared on grant of channel i.
  - All pending bits cleared in any cycle with MUTE=1.
- State machine (states IDLE, COUNT, GAP; registered):
  - IDLE:
    - If pending is nonzero and MUTE=0: grant the lowest set index, ACTIVE_ID<=idx, pending[idx]<=0, counter<=0, go to COUNT.
    - Otherwise stay in IDLE.
  - COUNT:
    - counter increments each cycle.
    - When counter==COUNTS[ACTIVE_ID]-1, go to GAP and clear counter.
    - MUTE does not abort a running pulse.
  - GAP: one cycle, then IDLE.
  - Illegal encodings return to IDLE.
- Outputs:
  - OUT[i] = (state==COUNT) && (ACTIVE_ID==i), combinational from registers.
  - BUSY = (state!=IDLE).
- Latency:
  - TRG_N sampled low at edge k with prev high → pending at edge k.
  - Grant and OUT high at edge k+1, provided state is IDLE and no lower index is pending.
- Pulse width: OUT high exactly COUNTS[i] cycles.
- Back-to-back service: at least 2 OUT-low cycles between pulses (GAP, then the IDLE grant cycle).
- Simultaneous events:
  - Edge arriving in the same cycle as a grant is registered into pending; it is considered at the next IDLE.
  - Edge on the channel being granted in that very IDLE cycle is latched, because the channel is not yet active; it yields one further pulse.
- Starvation: a continuously retriggered low-index channel may starve higher indices. This is accepted.

Decomposition:
- Package oneshot_pkg holds:
  - state_t enum {IDLE, COUNT, GAP} (logic [1:0])
  - default COUNTS constants for the sound channels
- Sub-module negedge_detect: one instance per channel, ports CLK, RESET, IN_N, DETECT. It holds prev_trg_n with reset value 0.
- Priority encoder, pending logic and FSM stay in oneshot_scheduler.

Test Plan (override NUM_CH=3, COUNTS={4,6,3}):
1. Single TRG_N[1] falling edge in idle → OUT[1] high exactly 6 cycles starting 1 cycle after the sampling edge; ACTIVE_ID=1; BUSY high 7 cycles; OUT[0]=OUT[2]=0 throughout.
2. TRG_N[0] and TRG_N[2] fall in the same cycle → OUT[0] high 4 cycles, OUT low 2 cycles, OUT[2] high 3 cycles; pending returns to 0.
3. TRG_N[1] toggled high/low twice during its own COUNT → pulse still exactly 6 cycles; no second pulse; BUSY drops after GAP.
4. During an OUT[2] pulse, edges on ch1 then ch0 → ch2 completes 3 cycles, then OUT[0] 4 cycles, then OUT[1] 6 cycles; each gap is 2 cycles.
5. RESET asserted mid-pulse of ch1 with a ch2 request pending; TRG_N[0] held low across release → OUT/BUSY go 0 asynchronously; no pulse after release until a fresh ch0 falling edge.
6. MUTE=1 during an OUT[0] pulse, with ch1 edges arriving → ch0 pulse finishes its 4 cycles; no ch1 pulse follows; after MUTE=0 a new ch1 edge yields a 6-cycle pulse.

Source files
------------

// File: rtl/oneshot_pkg.sv
// Shared types and default pulse lengths for the time-shared oneshot scheduler.
package oneshot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_CNT_W  = 20;

  // Channel 0 = paddle hit, 1 = wall bounce, 2 = score; index 0 is the rightmost entry.
  localparam logic [DEF_NUM_CH-1:0][DEF_CNT_W-1:0] DEF_COUNTS =
    {20'd114545, 20'd7159, 20'd28636};

endpackage

// File: rtl/oneshot_scheduler_negedge_detect.sv
// Falling-edge detector for one active-low trigger line.
// The history bit resets low, so a line already held low when reset is
// released does not look like a fresh falling edge.
module negedge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IN_N,
  output logic DETECT
);

  logic prev_q;

  // Remember the previous sample of the trigger line.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev_q <= 1'b0;
    else       prev_q <= IN_N;
  end

  assign DETECT = prev_q & ~IN_N;

endmodule

// File: rtl/oneshot_scheduler.sv
// Time-shares one monostable counter between NUM_CH trigger channels.
// Falling edges latch pending requests; the lowest pending index is served
// next, each with its own pulse length, and a GAP cycle separates pulses.
module oneshot_scheduler
  import oneshot_pkg::*;
#(
  parameter int                              NUM_CH = DEF_NUM_CH,
  parameter int                              CNT_W  = DEF_CNT_W,
  parameter logic [NUM_CH-1:0][CNT_W-1:0]    COUNTS = DEF_COUNTS,
  localparam int                             CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] TRG_N,
  input  logic              MUTE,
  output logic [NUM_CH-1:0] OUT,
  output logic              BUSY,
  output logic [CH_W-1:0]   ACTIVE_ID
);

  logic [NUM_CH-1:0] detect;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_last;
  logic [CH_W-1:0]   active_q, active_d, grant_idx;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              grant_vld, granting, chan_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_det
    negedge_detect u_det (
      .CLK    (CLK),
      .RESET  (RESET),
      .IN_N   (TRG_N[g]),
      .DETECT (detect[g])
    );
  end

  // Fixed-priority encoder: lowest pending index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
  end

  // Terminal count for the active channel. A length of 2**CNT_W is stored as
  // zero, so the wrap of the subtraction yields the all-ones terminal value.
  always_comb begin
    cnt_last = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q == CH_W'(i)) cnt_last = COUNTS[i] - CNT_W'(1);
    end
  end

  // Next-state, counter and pending-request logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    granting  = 1'b0;
    chan_busy = (state_q == COUNT) || (state_q == GAP);

    case (state_q)
      IDLE: begin
        if (grant_vld && !MUTE) begin
          granting = 1'b1;
          active_d = grant_idx;
          cnt_d    = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (cnt_q == cnt_last) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: state_d = IDLE;
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A new edge on the channel being granted this cycle still sets its bit,
    // because that channel is not active yet; edges on the running channel
    // are dropped since the oneshot is non-retriggerable.
    for (int i = 0; i < NUM_CH; i++) begin
      if (granting && (grant_idx == CH_W'(i))) pending_d[i] = 1'b0;
      if (detect[i] && !(chan_busy && (active_q == CH_W'(i)))) pending_d[i] = 1'b1;
    end

    if (MUTE) pending_d = '0;
  end

  // State, counter, active channel and pending register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // One-hot pulse outputs decoded from the registered state.
  always_comb begin
    OUT = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      OUT[i] = (state_q == COUNT) && (active_q == CH_W'(i));
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign ACTIVE_ID = active_q;

endmodule

// File: tb/tb_oneshot_scheduler.sv
// Directed bench for oneshot_scheduler with NUM_CH=3 and pulse lengths
// ch0=4, ch1=6, ch2=3. Expected pulses are queued when triggers are driven
// and popped by a monitor as each OUT pulse ends.
module tb_oneshot_scheduler;

  localparam int NCH = 3;
  localparam int CW  = 20;
  // Index 0 is the rightmost entry: ch0=4, ch1=6, ch2=3.
  localparam logic [NCH-1:0][CW-1:0] TB_COUNTS = {20'd3, 20'd6, 20'd4};

  logic           CLK = 1'b0;
  logic           RESET;
  logic [NCH-1:0] TRG_N;
  logic           MUTE;
  logic [NCH-1:0] OUT;
  logic           BUSY;
  logic [1:0]     ACTIVE_ID;

  oneshot_scheduler #(
    .NUM_CH (NCH),
    .CNT_W  (CW),
    .COUNTS (TB_COUNTS)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .TRG_N     (TRG_N),
    .MUTE      (MUTE),
    .OUT       (OUT),
    .BUSY      (BUSY),
    .ACTIVE_ID (ACTIVE_ID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int w;
    int gap;   // required OUT-low cycles before this pulse, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_len [NCH];
  int   gap_cnt  = 1000;
  int   last_gap = 1000;
  logic [NCH-1:0] prev_out = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int w, input int gap);
    exp_t e;
    e.ch = ch; e.w = w; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic pulse_done(input int ch, input int w);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_ch", ch, -1);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_ch", ch, e.ch);
      chk("pulse_width", w, e.w);
      if (e.gap >= 0) chk("pulse_gap", last_gap, e.gap);
    end
  endtask

  // Called once per cycle at the falling clock edge.
  task automatic monitor();
    chk("out_onehot", int'($countones(OUT) <= 1), 1);
    if (OUT != '0 && prev_out == '0) begin
      last_gap = gap_cnt;
      gap_cnt  = 0;
    end
    if (OUT == '0) gap_cnt++;
    for (int i = 0; i < NCH; i++) begin
      if (OUT[i]) run_len[i]++;
      else if (run_len[i] > 0) begin
        pulse_done(i, run_len[i]);
        run_len[i] = 0;
      end
    end
    prev_out = OUT;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    monitor();
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      tick();
      n++;
      quiet = BUSY ? 0 : quiet + 1;
    end
    chk("wait_idle_in_budget", int'(n < 300), 1);
  endtask

  initial begin
    int busy_cnt;
    for (int i = 0; i < NCH; i++) run_len[i] = 0;
    RESET = 1'b1;
    TRG_N = '1;
    MUTE  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_out", int'(OUT), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_active_id", int'(ACTIVE_ID), 0);
    RESET = 1'b0;
    tick();
    tick();

    // 1: single ch1 edge
    TRG_N[1] = 1'b0;
    push_exp(1, 6, -1);
    tick();
    chk("t1_out_at_sample_edge", int'(OUT), 0);
    tick();
    chk("t1_out_next_edge", int'(OUT), 3'b010);
    chk("t1_active_id", int'(ACTIVE_ID), 1);
    busy_cnt = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      busy_cnt++;
      tick();
    end
    chk("t1_busy_cycles", busy_cnt, 7);
    TRG_N = '1;
    wait_idle();
    chk("t1_queue_empty", exp_q.size(), 0);

    // 2: ch0 and ch2 fall together
    TRG_N[0] = 1'b0;
    TRG_N[2] = 1'b0;
    push_exp(0, 4, -1);
    push_exp(2, 3, 2);
    wait_idle();
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_pending_clear", int'(dut.pending_q), 0);
    TRG_N = '1;
    tick();

    // 3: ch1 retriggered during its own pulse
    TRG_N[1] = 1'b0;
    push_exp(1, 6, -1);
    tick();
    tick();
    TRG_N[1] = 1'b1; tick();
    TRG_N[1] = 1'b0; tick();
    TRG_N[1] = 1'b1; tick();
    TRG_N[1] = 1'b0; tick();
    wait_idle();
    chk("t3_queue_empty", exp_q.size(), 0);
    chk("t3_pending_clear", int'(dut.pending_q), 0);
    chk("t3_busy_low", int'(BUSY), 0);
    TRG_N = '1;
    tick();

    // 4: ch1 then ch0 arrive during a ch2 pulse
    TRG_N[2] = 1'b0;
    push_exp(2, 3, -1);
    tick();
    tick();
    TRG_N[1] = 1'b0; tick();
    TRG_N[0] = 1'b0; tick();
    push_exp(0, 4, 2);
    push_exp(1, 6, 2);
    wait_idle();
    chk("t4_queue_empty", exp_q.size(), 0);
    TRG_N = '1;
    tick();

    // 5: reset mid ch1 pulse with ch2 pending, ch0 held low over release
    TRG_N[1] = 1'b0;
    push_exp(1, 3, -1);
    tick();
    tick();
    tick();
    TRG_N[2] = 1'b0;
    tick();
    TRG_N[0] = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    chk("t5_async_out", int'(OUT), 0);
    chk("t5_async_busy", int'(BUSY), 0);
    tick();
    tick();
    chk("t5_reset_active_id", int'(ACTIVE_ID), 0);
    chk("t5_reset_pending", int'(dut.pending_q), 0);
    RESET = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (BUSY) busy_cnt++;
    end
    chk("t5_no_pulse_after_release", busy_cnt, 0);
    chk("t5_queue_empty", exp_q.size(), 0);
    TRG_N = 3'b001;
    tick();
    TRG_N[0] = 1'b0;
    push_exp(0, 4, -1);
    tick();
    chk("t5_fresh_edge_pending", int'(OUT), 0);
    tick();
    chk("t5_fresh_edge_out", int'(OUT), 3'b001);
    wait_idle();
    chk("t5_queue_empty_end", exp_q.size(), 0);
    TRG_N = '1;
    tick();

    // 6: MUTE during ch0 pulse drops ch1 edges
    TRG_N[0] = 1'b0;
    push_exp(0, 4, -1);
    tick();
    tick();
    MUTE = 1'b1;
    TRG_N[1] = 1'b0; tick();
    TRG_N[1] = 1'b1; tick();
    TRG_N[1] = 1'b0; tick();
    tick();
    tick();
    tick();
    chk("t6_mute_pending", int'(dut.pending_q), 0);
    chk("t6_mute_busy", int'(BUSY), 0);
    wait_idle();
    chk("t6_queue_after_mute", exp_q.size(), 0);
    MUTE = 1'b0;
    tick();
    TRG_N[1] = 1'b1; tick();
    TRG_N[1] = 1'b0;
    push_exp(1, 6, -1);
    wait_idle();
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
